// File: rtl/rv32_branch_predictor.sv
// rtl/rv32_branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict detection and statistics
module rv32_branch_predictor #(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        u_valid,
    input  logic [31:0] u_pc,
    input  logic        u_is_branch,
    input  logic        u_is_jal,
    input  logic        u_is_jalr,
    input  logic        u_took,
    input  logic [31:0] u_target,
    input  logic        u_pred_taken,
    input  logic [31:0] u_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [31:0]      tbl_target [ENTRIES];
    logic [1:0]       tbl_ctr    [ENTRIES];
    logic             tbl_jump   [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, is_cf;

    logic             wr_en;
    logic             nx_valid;
    logic [31:0]      nx_target;
    logic [1:0]       nx_ctr;
    logic             nx_jump;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[31:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[31:IDX_W+2];
    assign is_cf = u_valid && (u_is_branch || u_is_jal || u_is_jalr);

    // Lookup reads the current array contents, so a same-cycle update is not visible yet.
    always_comb begin
        f_hit       = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
        pred_taken  = !rst && f_valid && f_hit && (tbl_jump[f_idx] || tbl_ctr[f_idx][1]);
        pred_target = pred_taken ? tbl_target[f_idx] : f_pc + 32'd4;
    end

    always_comb begin
        mispredict  = !rst && u_valid &&
                      ((u_took != u_pred_taken) || (u_took && (u_target != u_pred_target)));
        redirect_pc = u_took ? u_target : u_pc + 32'd4;
    end

    always_comb begin
        u_hit     = tbl_valid[u_idx] && (tbl_tag[u_idx] == u_tag);
        wr_en     = 1'b0;
        nx_valid  = tbl_valid[u_idx];
        nx_target = tbl_target[u_idx];
        nx_ctr    = tbl_ctr[u_idx];
        nx_jump   = tbl_jump[u_idx];
        if (u_valid) begin
            if (u_is_jal || u_is_jalr) begin
                wr_en     = 1'b1;
                nx_valid  = 1'b1;
                nx_target = u_target;
                nx_jump   = 1'b1;
                nx_ctr    = 2'b11;
            end else if (u_is_branch) begin
                if (u_hit) begin
                    wr_en   = 1'b1;
                    nx_jump = 1'b0;
                    if (u_took) begin
                        nx_target = u_target;
                        if (tbl_ctr[u_idx] != 2'b11) nx_ctr = tbl_ctr[u_idx] + 2'd1;
                    end else if (tbl_ctr[u_idx] != 2'b00) begin
                        nx_ctr = tbl_ctr[u_idx] - 2'd1;
                    end
                end else if (u_took) begin
                    wr_en     = 1'b1;
                    nx_valid  = 1'b1;
                    nx_target = u_target;
                    nx_jump   = 1'b0;
                    nx_ctr    = 2'b10;
                end
            end else if (u_hit) begin
                // A non-control instruction hit means the entry belongs to an alias; drop it.
                wr_en    = 1'b1;
                nx_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b01;
                tbl_jump[i]   <= 1'b0;
            end
        end else if (wr_en) begin
            tbl_valid[u_idx]  <= nx_valid;
            tbl_tag[u_idx]    <= u_tag;
            tbl_target[u_idx] <= nx_target;
            tbl_ctr[u_idx]    <= nx_ctr;
            tbl_jump[u_idx]   <= nx_jump;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (is_cf && (stat_branches != 32'hFFFF_FFFF))
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
endmodule

// File: tb/tb_rv32_branch_predictor.sv
// tb/tb_rv32_branch_predictor.sv - scoreboard bench for rv32_branch_predictor with a behavioural BTB model
module tb_rv32_branch_predictor;
    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        u_valid;
    logic [31:0] u_pc;
    logic        u_is_branch, u_is_jal, u_is_jalr;
    logic        u_took;
    logic [31:0] u_target;
    logic        u_pred_taken;
    logic [31:0] u_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches, stat_mispredicts;

    always #5 clk = ~clk;

    rv32_branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .u_valid(u_valid), .u_pc(u_pc),
        .u_is_branch(u_is_branch), .u_is_jal(u_is_jal), .u_is_jalr(u_is_jalr),
        .u_took(u_took), .u_target(u_target),
        .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        mp;
        logic [31:0] rpc;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerrors = 0;

    // Behavioural BTB: entries addressed by word number modulo table size.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_jump   [ENTRIES];
    logic [31:0] m_sb, m_sm;

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_predict(logic [31:0] pc);
        int unsigned i = idx_of(pc);
        return m_hit(pc) && (m_jump[i] || m_ctr[i] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
            m_jump[i]   = 1'b0;
        end
        m_sb = '0;
        m_sm = '0;
    endtask

    task automatic model_update(bit mp);
        int unsigned i;
        bit hit;
        if (!u_valid) return;
        i   = idx_of(u_pc);
        hit = m_hit(u_pc);
        if ((u_is_branch || u_is_jal || u_is_jalr) && m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 1;
        if (mp && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
        if (u_is_jal || u_is_jalr) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(u_pc); m_target[i] = u_target;
            m_jump[i] = 1'b1;  m_ctr[i] = 3;
        end else if (u_is_branch) begin
            if (hit) begin
                m_ctr[i]  = u_took ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                   : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (u_took) m_target[i] = u_target;
                m_jump[i] = 1'b0;
            end else if (u_took) begin
                m_valid[i] = 1'b1; m_tag[i] = tag_of(u_pc); m_target[i] = u_target;
                m_jump[i] = 1'b0;  m_ctr[i] = 2;
            end
        end else if (hit) begin
            m_valid[i] = 1'b0;
        end
    endtask

    // Inputs are already applied; record the expected response, advance the model, then clock.
    task automatic issue();
        exp_t e;
        if (rst) model_reset();
        e.pt   = !rst && f_valid && m_predict(f_pc);
        e.ptgt = e.pt ? m_target[idx_of(f_pc)] : f_pc + 32'd4;
        e.mp   = !rst && u_valid &&
                 ((u_took != u_pred_taken) || (u_took && u_target != u_pred_target));
        e.rpc  = u_took ? u_target : u_pc + 32'd4;
        e.sb   = m_sb;
        e.sm   = m_sm;
        exp_q.push_back(e);
        if (!rst) model_update(e.mp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_u();
        u_valid = 0; u_pc = '0; u_is_branch = 0; u_is_jal = 0; u_is_jalr = 0;
        u_took = 0; u_target = '0; u_pred_taken = 0; u_pred_target = '0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        f_valid = 1'b1;
        f_pc    = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input bit br, input bit jal, input bit jalr,
                       input bit took, input logic [31:0] tgt,
                       input bit ppt, input logic [31:0] ptgt);
        u_valid = 1; u_pc = pc; u_is_branch = br; u_is_jal = jal; u_is_jalr = jalr;
        u_took = took; u_target = tgt; u_pred_taken = ppt; u_pred_target = ptgt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pred_taken",       {31'd0, pred_taken}, {31'd0, e.pt});
                chk("pred_target",      pred_target,         e.ptgt);
                chk("mispredict",       {31'd0, mispredict}, {31'd0, e.mp});
                chk("redirect_pc",      redirect_pc,         e.rpc);
                chk("stat_branches",    stat_branches,       e.sb);
                chk("stat_mispredicts", stat_mispredicts,    e.sm);
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        return ($urandom_range(0, 2) * 4 * ENTRIES) + ($urandom_range(0, 7) * 4)
               + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    endfunction

    initial begin : driver
        logic [31:0] pc;
        int          budget;
        rst = 1; f_valid = 0; f_pc = '0;
        idle_u();
        @(posedge clk);
        #1;
        fetch(32'h100);
        issue();
        issue();
        rst = 0;
        issue();

        upd(32'h100, 0, 1, 0, 1, 32'h200, 0, 32'h0);
        issue();
        idle_u(); issue();
        fetch(32'h200); issue();

        fetch(32'h40);
        upd(32'h40, 1, 0, 0, 1, 32'h10, 0, 32'h44); issue();
        idle_u(); issue();
        upd(32'h40, 1, 0, 0, 1, 32'h10, 1, 32'h10); issue();
        upd(32'h40, 1, 0, 0, 0, 32'h10, 1, 32'h10); issue();
        upd(32'h40, 1, 0, 0, 0, 32'h10, 1, 32'h10); issue();
        idle_u(); issue();

        fetch(32'h80);
        upd(32'h80, 1, 0, 0, 0, 32'h0, 0, 32'h84); issue();
        idle_u(); issue();

        fetch(32'h100);
        upd(32'h100, 0, 0, 0, 0, 32'h0, 1, 32'h200); issue();
        idle_u(); issue();

        fetch(32'h40);
        upd(32'h40, 1, 0, 0, 1, 32'h10, 0, 32'h44); issue();
        upd(32'h40, 1, 0, 0, 0, 32'h10, 1, 32'h10); issue();
        idle_u(); issue();
        upd(32'h100, 0, 0, 1, 1, 32'h300, 0, 32'h104); issue();
        idle_u(); fetch(32'h100);
        rst = 1; issue();
        rst = 0; issue();

        for (int n = 0; n < 3000; n++) begin
            f_valid = ($urandom_range(0, 3) != 0);
            f_pc    = rand_pc();
            if ($urandom_range(0, 3) == 0) begin
                idle_u();
            end else begin
                pc = rand_pc();
                upd(pc, $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 1), rand_pc(), 0, pc + 32'd4);
                if ($urandom_range(0, 3) != 0) begin
                    u_pred_taken  = m_predict(pc);
                    u_pred_target = u_pred_taken ? m_target[idx_of(pc)] : pc + 32'd4;
                end else begin
                    u_pred_taken  = $urandom_range(0, 1);
                    u_pred_target = rand_pc();
                end
                if (u_is_jal || u_is_jalr) u_took = ($urandom_range(0, 7) != 0);
            end
            rst = ($urandom_range(0, 499) == 0);
            issue();
        end
        rst = 0; idle_u(); f_valid = 0;

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
